// File: rtl/truth_table_extractor.sv
// Sweeps all eight 3-bit input patterns onto a combinational gate block, samples
// its synchronized output and assembles the 8-bit function code.
module truth_table_extractor #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       match
);

    if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 2..255");
    end
    if (SETTLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cnt_w
        $error("CNT_W too narrow for SETTLE_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q;
    logic [2:0]       pat_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       exp_q;
    logic [7:0]       code_q;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;
    logic             match_q;
    logic             sync1_q;
    logic             sync2_q;

    // The two synchronizer stages are part of the settle window, not added to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= dut_out;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            code_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (abort) begin
                        pat_q   <= '0;
                        valid_q <= 1'b0;
                    end else if (start) begin
                        state_q <= APPLY;
                        pat_q   <= '0;
                        cnt_q   <= '0;
                        exp_q   <= expected;
                        code_q  <= '0;
                        valid_q <= 1'b0;
                        match_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        state_q <= IDLE;
                        pat_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        pat_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end else begin
                        code_q[3'd7 - pat_q] <= sync2_q;
                        if (pat_q == 3'd7) begin
                            state_q <= DONE;
                        end else begin
                            pat_q   <= pat_q + 3'd1;
                            cnt_q   <= '0;
                            state_q <= APPLY;
                        end
                    end
                end
                DONE: begin
                    // Registered outputs: done/code_valid appear the cycle after DONE.
                    done_q  <= 1'b1;
                    valid_q <= !abort;
                    match_q <= (code_q == exp_q);
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                    if (abort) begin
                        pat_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in1        = pat_q[2];
    assign in2        = pat_q[1];
    assign in3        = pat_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign code       = code_q;
    assign code_valid = valid_q;
    assign match      = match_q;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Randomized self-checking bench for truth_table_extractor against a timeline
// model of pattern application, settle window and output delay.
module tb_truth_table_extractor;

    localparam int S_A = 4;
    localparam int S_B = 2;
    localparam int S_C = 5;
    localparam int DLY = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] expected;
    int         errors = 0;
    int         checks = 0;

    // Instance A: combinational gate block, default settle.
    logic       start_a, abort_a;
    logic       in1_a, in2_a, in3_a, dut_out_a, busy_a, done_a, valid_a, match_a;
    logic [7:0] code_a;
    logic [7:0] func_a;
    logic [2:0] pat_a;

    // Instances B/C: gate block with a 3-cycle output delay.
    logic       start_b;
    logic       abort_b;
    logic       in1_b, in2_b, in3_b, dut_out_b, busy_b, done_b, valid_b, match_b;
    logic       in1_c, in2_c, in3_c, dut_out_c, busy_c, done_c, valid_c, match_c;
    logic [7:0] code_b, code_c;
    logic [7:0] func_b;
    logic [2:0] hb0 = '0, hb1 = '0, hb2 = '0;
    logic [2:0] hc0 = '0, hc1 = '0, hc2 = '0;

    always #5 clk = ~clk;

    assign pat_a     = {in1_a, in2_a, in3_a};
    assign dut_out_a = func_a[3'd7 - pat_a];

    always @(posedge clk) begin
        hb0 <= {in1_b, in2_b, in3_b};
        hb1 <= hb0;
        hb2 <= hb1;
        hc0 <= {in1_c, in2_c, in3_c};
        hc1 <= hc0;
        hc2 <= hc1;
    end
    assign dut_out_b = func_b[3'd7 - hb2];
    assign dut_out_c = func_b[3'd7 - hc2];

    truth_table_extractor #(.SETTLE_CYCLES(S_A), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .expected(expected),
        .in1(in1_a), .in2(in2_a), .in3(in3_a), .dut_out(dut_out_a), .busy(busy_a),
        .done(done_a), .code(code_a), .code_valid(valid_a), .match(match_a)
    );

    truth_table_extractor #(.SETTLE_CYCLES(S_B), .CNT_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .expected(expected),
        .in1(in1_b), .in2(in2_b), .in3(in3_b), .dut_out(dut_out_b), .busy(busy_b),
        .done(done_b), .code(code_b), .code_valid(valid_b), .match(match_b)
    );

    truth_table_extractor #(.SETTLE_CYCLES(S_C), .CNT_W(8)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .expected(expected),
        .in1(in1_c), .in2(in2_c), .in3(in3_c), .dut_out(dut_out_c), .busy(busy_c),
        .done(done_c), .code(code_c), .code_valid(valid_c), .match(match_c)
    );

    // Code a sweep reads back when the gate output lags its inputs by d cycles.
    // Pattern p is driven from offset p*(s+1); the value in the synchronizer's
    // last stage at the sample cycle left the gate at offset p*(s+1)+s-2.
    function automatic logic [7:0] model_code(input logic [7:0] f, input int s,
                                              input int d, input int prior);
        logic [7:0] m;
        int t, pp;
        m = '0;
        for (int p = 0; p < 8; p++) begin
            t  = p * (s + 1) + s - 2 - d;
            pp = (t < 0) ? prior : t / (s + 1);
            m[7-p] = f[7-pp];
        end
        return m;
    endfunction

    // Full sweep on instance A; optionally a stray start at cycle inj_k.
    task automatic run_sweep(input logic [7:0] exp_in, input int inj_k,
                             output int lat, output int ndone,
                             output bit seq_ok, output logic busy_at_done,
                             output logic busy_first);
        int pe;
        lat = -1; ndone = 0; seq_ok = 1'b1; busy_at_done = 1'b1; busy_first = 1'b0;
        expected = exp_in;
        start_a  = 1'b1;
        @(negedge clk);
        start_a  = 1'b0;
        expected = ~exp_in;
        for (int k = 0; k < 120; k++) begin
            if (k == 0) busy_first = busy_a;
            if (done_a) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    busy_at_done = busy_a;
                end
            end
            pe = (k < 8 * (S_A + 1)) ? k / (S_A + 1) : 7;
            if (int'(pat_a) != pe) seq_ok = 1'b0;
            start_a = (k == inj_k);
            if (lat >= 0 && k >= lat + 3) break;
            @(negedge clk);
        end
        start_a = 1'b0;
    endtask

    task automatic check_sweep(input string tag, input logic [7:0] f,
                               input logic [7:0] e, input int inj_k);
        int lat, nd;
        bit seq;
        logic bd, bf;
        func_a = f;
        run_sweep(e, inj_k, lat, nd, seq, bd, bf);
        checks++; if (lat !== 8 * (S_A + 1) + 1) begin errors++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, 8 * (S_A + 1) + 1); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL %s done_count: got %0d expected 1", tag, nd); end
        checks++; if (code_a !== f) begin errors++; $display("FAIL %s code: got %02h expected %02h", tag, code_a, f); end
        checks++; if (match_a !== (f == e)) begin errors++; $display("FAIL %s match: got %0b expected %0b", tag, match_a, f == e); end
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL %s code_valid: got %0b expected 1", tag, valid_a); end
        checks++; if (bd !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL %s busy_after: got %0b/%0b expected 0", tag, bd, busy_a); end
        checks++; if (bf !== 1'b1) begin errors++; $display("FAIL %s busy_first: got %0b expected 1", tag, bf); end
        checks++; if (!seq) begin errors++; $display("FAIL %s pattern_seq: got mismatch expected held patterns", tag); end
        checks++; if (pat_a !== 3'd7) begin errors++; $display("FAIL %s pattern_hold: got %0d expected 7", tag, pat_a); end
    endtask

    task automatic check_reset_values(input string tag);
        checks++; if (pat_a !== 3'd0) begin errors++; $display("FAIL %s in: got %0d expected 0", tag, pat_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL %s busy: got %0b expected 0", tag, busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL %s done: got %0b expected 0", tag, done_a); end
        checks++; if (code_a !== 8'h00) begin errors++; $display("FAIL %s code: got %02h expected 00", tag, code_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL %s code_valid: got %0b expected 0", tag, valid_a); end
        checks++; if (match_a !== 1'b0) begin errors++; $display("FAIL %s match: got %0b expected 0", tag, match_a); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        expected = 8'h00; func_a = 8'h00; func_b = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset_held");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset_released");
    endtask

    task automatic test_function_1f;
        check_sweep("fn1f", 8'h1F, 8'h1F, -1);
    endtask

    task automatic test_and3_and_const;
        check_sweep("and3", 8'h01, 8'h1F, -1);
        repeat (2) @(negedge clk);
        check_sweep("const1", 8'hFF, 8'hFF, -1);
    endtask

    task automatic test_random;
        logic [7:0] f, e;
        for (int i = 0; i < 6; i++) begin
            f = 8'($urandom);
            e = ($urandom_range(0, 1) == 1) ? f : 8'($urandom);
            repeat ($urandom_range(1, 4)) @(negedge clk);
            check_sweep("random", f, e, -1);
        end
    endtask

    task automatic test_start_ignored;
        @(negedge clk);
        check_sweep("start_busy", 8'hA6, 8'hA6, 3 * (S_A + 1) + 2);
    endtask

    task automatic test_abort;
        int nd;
        func_a   = 8'h5C;
        expected = 8'h5C;
        start_a  = 1'b1;
        @(negedge clk);
        start_a  = 1'b0;
        repeat (5 * (S_A + 1) + 2) @(negedge clk);
        checks++; if (pat_a !== 3'd5) begin errors++; $display("FAIL abort_at_p5 in: got %0d expected 5", pat_a); end
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort busy: got %0b expected 0", busy_a); end
        checks++; if (pat_a !== 3'd0) begin errors++; $display("FAIL abort in: got %0d expected 0", pat_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL abort code_valid: got %0b expected 0", valid_a); end
        nd = 0;
        for (int k = 0; k < 60; k++) begin
            if (done_a) nd++;
            @(negedge clk);
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL abort no_done: got %0d expected 0", nd); end
        // abort and start together in IDLE: abort wins
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_start busy: got %0b expected 0", busy_a); end
        repeat (2) @(negedge clk);
        check_sweep("after_abort", 8'h5C, 8'h5C, -1);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        checks++; if (valid_a !== 1'b0 || pat_a !== 3'd0) begin errors++; $display("FAIL idle_abort valid/in: got %0b/%0d expected 0/0", valid_a, pat_a); end
        checks++; if (code_a !== 8'h5C) begin errors++; $display("FAIL idle_abort code: got %02h expected 5c", code_a); end
    endtask

    task automatic test_async_reset;
        func_a   = 8'hE7;
        expected = 8'hE7;
        start_a  = 1'b1;
        @(negedge clk);
        start_a  = 1'b0;
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_sweep("post_reset", 8'h3B, 8'h3B, -1);
    endtask

    task automatic sweep_delayed(input string tag, input logic [7:0] f, input int prior);
        int lb, lc;
        logic [7:0] mb, mc;
        func_b   = f;
        expected = f;
        lb = -1; lc = -1;
        start_b  = 1'b1;
        @(negedge clk);
        start_b  = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (done_b && lb < 0) lb = k;
            if (done_c && lc < 0) lc = k;
            if (lb >= 0 && lc >= 0) break;
            @(negedge clk);
        end
        mb = model_code(f, S_B, DLY, prior);
        mc = model_code(f, S_C, DLY, prior);
        checks++; if (lb !== 8 * (S_B + 1) + 1) begin errors++; $display("FAIL %s latency_s2: got %0d expected %0d", tag, lb, 8 * (S_B + 1) + 1); end
        checks++; if (lc !== 8 * (S_C + 1) + 1) begin errors++; $display("FAIL %s latency_s5: got %0d expected %0d", tag, lc, 8 * (S_C + 1) + 1); end
        checks++; if (code_b !== mb) begin errors++; $display("FAIL %s code_s2: got %02h expected %02h", tag, code_b, mb); end
        checks++; if (code_c !== mc) begin errors++; $display("FAIL %s code_s5: got %02h expected %02h", tag, code_c, mc); end
        checks++; if (match_b !== (mb == f) || match_c !== (mc == f)) begin errors++; $display("FAIL %s match_s2_s5: got %0b%0b expected %0b%0b", tag, match_b, match_c, mb == f, mc == f); end
    endtask

    task automatic test_settle_window;
        sweep_delayed("delay_prior0", 8'h1F, 0);
        repeat (5) @(negedge clk);
        sweep_delayed("delay_prior7", 8'($urandom), 7);
        repeat (5) @(negedge clk);
        sweep_delayed("delay_prior7b", 8'h96, 7);
    endtask

    initial begin
        test_reset();
        test_function_1f();
        test_and3_and_const();
        test_random();
        test_start_ignored();
        test_abort();
        test_async_reset();
        test_settle_window();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
